// File: rtl/tohost_pkg.sv
// Shared syscall code constants and entry-layout helpers for the tohost mailbox.
package tohost_pkg;

    localparam int CODE_NONE     = 0;
    localparam int CODE_EXIT     = 1;
    localparam int CODE_PUTCHAR  = 3;
    localparam int CODE_PUTFLOAT = 4;

    // Queue entries are packed as {channel, code, arg}, arg in the low bits.
    function automatic int entry_width(input int chan_w, input int code_w, input int arg_w);
        return chan_w + code_w + arg_w;
    endfunction

    function automatic int entry_code_lsb(input int arg_w);
        return arg_w;
    endfunction

endpackage

// File: rtl/tohost_fifo.sv
// Synchronous FIFO with occupancy count; head is read straight from storage.
module tohost_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [W-1:0]    din,
    input  logic            pop,
    output logic [W-1:0]    dout,
    output logic            valid,
    output logic            full,
    output logic [CNTW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign valid = (count_q != '0);
    assign full  = (count_q == CNTW'(DEPTH));
    assign count = count_q;
    assign dout  = mem[rd_q];

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && valid;
        wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_q] <= din;
    end

endmodule

// File: rtl/tohost_mailbox.sv
// Round-robin collector of per-tile tohost syscall requests into a single host stream,
// with a sticky exit latch and optional pin-level change detection.
module tohost_mailbox
    import tohost_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int CODE_WIDTH   = 8,
    parameter int ARG_WIDTH    = 32,
    parameter int DEPTH        = 8,
    parameter int LEVEL_MODE   = 0,
    parameter int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int CNTW         = $clog2(DEPTH + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            io_req_valid,
    output logic [NUM_CHANNELS-1:0]            io_req_ready,
    input  logic [NUM_CHANNELS*CODE_WIDTH-1:0] io_req_code,
    input  logic [NUM_CHANNELS*ARG_WIDTH-1:0]  io_req_arg,
    output logic                               io_out_valid,
    input  logic                               io_out_ready,
    output logic [CW-1:0]                      io_out_channel,
    output logic [CODE_WIDTH-1:0]              io_out_code,
    output logic [ARG_WIDTH-1:0]               io_out_arg,
    output logic                               io_exited,
    output logic [CW-1:0]                      io_exit_channel,
    output logic [ARG_WIDTH-1:0]               io_exit_code,
    output logic [CNTW-1:0]                    io_count,
    output logic [15:0]                        io_drops
);

    localparam int EW = entry_width(CW, CODE_WIDTH, ARG_WIDTH);

    logic [NUM_CHANNELS-1:0]                 req, grant;
    logic [NUM_CHANNELS-1:0][CODE_WIDTH-1:0] src_code;
    logic [NUM_CHANNELS-1:0][ARG_WIDTH-1:0]  src_arg;
    logic [CW-1:0]                           last_q, last_d;
    logic [CW-1:0]                           acc_idx;
    logic [CODE_WIDTH-1:0]                   acc_code;
    logic [ARG_WIDTH-1:0]                    acc_arg;
    logic                                    found, accept, enq;
    int                                      arb_idx;

    logic [NUM_CHANNELS-1:0][CODE_WIDTH-1:0] prev_q, prev_d;
    logic [NUM_CHANNELS-1:0]                 pend_q, pend_d;
    logic [NUM_CHANNELS-1:0][CODE_WIDTH-1:0] cap_code_q, cap_code_d;
    logic [NUM_CHANNELS-1:0][ARG_WIDTH-1:0]  cap_arg_q, cap_arg_d;
    logic [4:0]                              drop_inc;
    logic [16:0]                             drop_sum;
    logic [15:0]                             drops_q, drops_d;

    logic                                    exited_q, exited_d;
    logic [CW-1:0]                           exit_ch_q, exit_ch_d;
    logic [ARG_WIDTH-1:0]                    exit_arg_q, exit_arg_d;

    logic [EW-1:0]                           fifo_dout;
    logic                                    fifo_valid, fifo_full;

    // Level mode arbitrates over captured events; handshake mode over live requests.
    assign req      = (LEVEL_MODE != 0) ? pend_q     : io_req_valid;
    assign src_code = (LEVEL_MODE != 0) ? cap_code_q : io_req_code;
    assign src_arg  = (LEVEL_MODE != 0) ? cap_arg_q  : io_req_arg;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        acc_idx = '0;
        arb_idx = 0;
        for (int off = 1; off <= NUM_CHANNELS; off++) begin
            arb_idx = (int'(last_q) + off) % NUM_CHANNELS;
            if (!found && req[arb_idx]) begin
                grant[arb_idx] = 1'b1;
                found          = 1'b1;
                acc_idx        = CW'(arb_idx);
            end
        end
    end

    always_comb begin
        io_req_ready = (!fifo_full && !exited_q) ? grant : '0;
        accept       = found && !fifo_full && !exited_q;
        acc_code     = src_code[acc_idx];
        acc_arg      = src_arg[acc_idx];
        enq          = accept && (acc_code != CODE_WIDTH'(CODE_NONE));
        last_d       = accept ? acc_idx : last_q;
        exited_d     = exited_q;
        exit_ch_d    = exit_ch_q;
        exit_arg_d   = exit_arg_q;
        if (accept && acc_code == CODE_WIDTH'(CODE_EXIT)) begin
            exited_d   = 1'b1;
            exit_ch_d  = acc_idx;
            exit_arg_d = acc_arg;
        end
    end

    // A fresh event on a channel whose previous event was not taken this cycle is a drop.
    always_comb begin
        prev_d     = io_req_code;
        pend_d     = pend_q & ~io_req_ready;
        cap_code_d = cap_code_q;
        cap_arg_d  = cap_arg_q;
        drop_inc   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (LEVEL_MODE != 0 && io_req_code[i*CODE_WIDTH +: CODE_WIDTH] != prev_q[i]
                && io_req_code[i*CODE_WIDTH +: CODE_WIDTH] != '0) begin
                pend_d[i]     = 1'b1;
                cap_code_d[i] = io_req_code[i*CODE_WIDTH +: CODE_WIDTH];
                cap_arg_d[i]  = io_req_arg[i*ARG_WIDTH +: ARG_WIDTH];
                if (pend_q[i] && !io_req_ready[i]) drop_inc = drop_inc + 5'd1;
            end
        end
        drop_sum = {1'b0, drops_q} + 17'(drop_inc);
        drops_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q     <= CW'(NUM_CHANNELS - 1);
            prev_q     <= '0;
            pend_q     <= '0;
            drops_q    <= '0;
            exited_q   <= 1'b0;
            exit_ch_q  <= '0;
            exit_arg_q <= '0;
        end else begin
            last_q     <= last_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            drops_q    <= drops_d;
            exited_q   <= exited_d;
            exit_ch_q  <= exit_ch_d;
            exit_arg_q <= exit_arg_d;
        end
    end

    always_ff @(posedge clock) begin
        cap_code_q <= cap_code_d;
        cap_arg_q  <= cap_arg_d;
    end

    tohost_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (enq),
        .din   ({acc_idx, acc_code, acc_arg}),
        .pop   (io_out_ready),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .count (io_count)
    );

    // Storage is not reset, so the head fields are masked while the queue is empty.
    assign io_out_valid    = fifo_valid;
    assign io_out_arg      = fifo_valid ? fifo_dout[ARG_WIDTH-1:0] : '0;
    assign io_out_code     = fifo_valid ? fifo_dout[entry_code_lsb(ARG_WIDTH) +: CODE_WIDTH] : '0;
    assign io_out_channel  = fifo_valid ? fifo_dout[EW-1 -: CW] : '0;
    assign io_exited       = exited_q;
    assign io_exit_channel = exit_ch_q;
    assign io_exit_code    = exit_arg_q;
    assign io_drops        = drops_q;

endmodule

// File: tb/tb_tohost_mailbox.sv
// Directed bench for tohost_mailbox: a handshake instance (DEPTH 8) and a level-mode instance (DEPTH 2).
module tb_tohost_mailbox;

    logic clock;
    logic reset;

    logic [1:0]  hs_valid, hs_ready;
    logic [15:0] hs_code;
    logic [63:0] hs_arg;
    logic        hs_out_valid, hs_out_ready;
    logic [0:0]  hs_out_channel;
    logic [7:0]  hs_out_code;
    logic [31:0] hs_out_arg;
    logic        hs_exited;
    logic [0:0]  hs_exit_channel;
    logic [31:0] hs_exit_code;
    logic [3:0]  hs_count;
    logic [15:0] hs_drops;

    logic [1:0]  lv_valid, lv_ready;
    logic [15:0] lv_code;
    logic [63:0] lv_arg;
    logic        lv_out_valid, lv_out_ready;
    logic [0:0]  lv_out_channel;
    logic [7:0]  lv_out_code;
    logic [31:0] lv_out_arg;
    logic        lv_exited;
    logic [0:0]  lv_exit_channel;
    logic [31:0] lv_exit_code;
    logic [1:0]  lv_count;
    logic [15:0] lv_drops;

    int vectors;
    int miscompares;
    int acc;

    tohost_mailbox #(.NUM_CHANNELS(2), .CODE_WIDTH(8), .ARG_WIDTH(32), .DEPTH(8), .LEVEL_MODE(0)) u_hs (
        .clock(clock), .reset(reset),
        .io_req_valid(hs_valid), .io_req_ready(hs_ready),
        .io_req_code(hs_code), .io_req_arg(hs_arg),
        .io_out_valid(hs_out_valid), .io_out_ready(hs_out_ready),
        .io_out_channel(hs_out_channel), .io_out_code(hs_out_code), .io_out_arg(hs_out_arg),
        .io_exited(hs_exited), .io_exit_channel(hs_exit_channel), .io_exit_code(hs_exit_code),
        .io_count(hs_count), .io_drops(hs_drops)
    );

    tohost_mailbox #(.NUM_CHANNELS(2), .CODE_WIDTH(8), .ARG_WIDTH(32), .DEPTH(2), .LEVEL_MODE(1)) u_lv (
        .clock(clock), .reset(reset),
        .io_req_valid(lv_valid), .io_req_ready(lv_ready),
        .io_req_code(lv_code), .io_req_arg(lv_arg),
        .io_out_valid(lv_out_valid), .io_out_ready(lv_out_ready),
        .io_out_channel(lv_out_channel), .io_out_code(lv_out_code), .io_out_arg(lv_out_arg),
        .io_exited(lv_exited), .io_exit_channel(lv_exit_channel), .io_exit_code(lv_exit_code),
        .io_count(lv_count), .io_drops(lv_drops)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        hs_valid = '0; hs_code = '0; hs_arg = '0; hs_out_ready = 1'b0;
        lv_valid = '0; lv_code = '0; lv_arg = '0; lv_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", hs_out_valid, 0);
        chk("rst_count", hs_count, 0);
        chk("rst_exited", hs_exited, 0);
        chk("rst_exit_code", hs_exit_code, 0);
        chk("rst_out_arg", hs_out_arg, 0);
        chk("rst_ready", hs_ready, 0);
        chk("rst_drops", lv_drops, 0);
        reset = 1'b0;

        // Basic order
        hs_out_ready = 1'b1;
        hs_valid = 2'b01; hs_code[7:0] = 8'd3; hs_arg[31:0] = 32'h41;
        #1 chk("basic_rdy0", hs_ready, 2'b01);
        tick();
        chk("basic_h0_valid", hs_out_valid, 1);
        chk("basic_h0_ch", hs_out_channel, 0);
        chk("basic_h0_code", hs_out_code, 3);
        chk("basic_h0_arg", hs_out_arg, 32'h41);
        chk("basic_cnt1", hs_count, 1);
        hs_valid = 2'b10; hs_code[15:8] = 8'd4; hs_arg[63:32] = 32'h3F800000;
        #1 chk("basic_rdy1", hs_ready, 2'b10);
        tick();
        chk("basic_h1_ch", hs_out_channel, 1);
        chk("basic_h1_code", hs_out_code, 4);
        chk("basic_h1_arg", hs_out_arg, 32'h3F800000);
        chk("basic_cnt_same", hs_count, 1);
        hs_valid = 2'b00;
        tick();
        chk("basic_cnt0", hs_count, 0);
        chk("basic_empty", hs_out_valid, 0);

        // Fairness: last grant was ch1, so ch0 leads
        hs_valid = 2'b11; hs_code = {8'd3, 8'd3};
        for (int k = 0; k < 16; k++) begin
            hs_arg = {32'(k), 32'(k)};
            #1 chk("rr_rdy", hs_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            chk("rr_head_ch", hs_out_channel, k % 2);
            chk("rr_head_arg", hs_out_arg, k);
        end
        hs_valid = 2'b00;
        tick();
        chk("rr_drained", hs_count, 0);

        // Backpressure
        hs_out_ready = 1'b0;
        hs_valid = 2'b01; hs_code[7:0] = 8'd3;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            hs_arg[31:0] = 32'h100 + 32'(i);
            #1 if (hs_ready[0]) acc++;
            tick();
        end
        chk("bp_accepts", acc, 8);
        chk("bp_count", hs_count, 8);
        chk("bp_rdy_low", hs_ready, 0);
        chk("bp_head", hs_out_arg, 32'h100);
        hs_out_ready = 1'b1;
        #1 chk("bp_rdy_indep", hs_ready, 0);
        tick();
        chk("bp_count7", hs_count, 7);
        chk("bp_head2", hs_out_arg, 32'h101);
        hs_out_ready = 1'b0; hs_arg[31:0] = 32'h1FF;
        #1 chk("bp_rdy_back", hs_ready, 2'b01);
        tick();
        chk("bp_count8", hs_count, 8);
        hs_valid = 2'b00; hs_out_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drained", hs_count, 0);

        // Exit
        hs_out_ready = 1'b0;
        hs_valid = 2'b10; hs_code[15:8] = 8'd1; hs_arg[63:32] = 32'd7;
        #1 chk("exit_rdy", hs_ready, 2'b10);
        tick();
        chk("exit_flag", hs_exited, 1);
        chk("exit_ch", hs_exit_channel, 1);
        chk("exit_code", hs_exit_code, 7);
        chk("exit_queued", hs_count, 1);
        chk("exit_head_code", hs_out_code, 1);
        hs_valid = 2'b11; hs_code = {8'd3, 8'd3};
        #1 chk("exit_blocks", hs_ready, 0);
        tick();
        tick();
        chk("exit_no_enq", hs_count, 1);
        hs_out_ready = 1'b1;
        tick();
        chk("exit_drained", hs_count, 0);
        chk("exit_sticky", hs_exited, 1);
        hs_valid = 2'b00;

        // Reset mid-run with five queued entries and exit latched
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hs_out_ready = 1'b0;
        hs_valid = 2'b01; hs_code[7:0] = 8'd3;
        for (int i = 0; i < 4; i++) begin
            hs_arg[31:0] = 32'h200 + 32'(i);
            tick();
        end
        hs_code[7:0] = 8'd1; hs_arg[31:0] = 32'd9;
        tick();
        chk("mid_count5", hs_count, 5);
        chk("mid_exited", hs_exited, 1);
        hs_valid = 2'b00;
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", hs_out_valid, 0);
        chk("mid_rst_count", hs_count, 0);
        chk("mid_rst_exited", hs_exited, 0);
        chk("mid_rst_exit_code", hs_exit_code, 0);
        chk("mid_rst_exit_ch", hs_exit_channel, 0);
        chk("mid_rst_arg", hs_out_arg, 0);
        chk("mid_rst_code", hs_out_code, 0);
        tick();
        reset = 1'b0;
        hs_valid = 2'b10; hs_code[15:8] = 8'd3; hs_arg[63:32] = 32'h55;
        #1 chk("post_rst_rdy", hs_ready, 2'b10);
        tick();
        chk("post_rst_valid", hs_out_valid, 1);
        chk("post_rst_ch", hs_out_channel, 1);
        chk("post_rst_arg", hs_out_arg, 32'h55);
        chk("post_rst_count", hs_count, 1);
        hs_valid = 2'b00;

        // Level mode (DEPTH 2): fill with two ch1 events, then 0->3->3->4 on ch0
        lv_code[15:8] = 8'd5; lv_arg[63:32] = 32'hA;
        tick();
        chk("lv_evt_pending", lv_ready, 2'b10);
        chk("lv_evt_latency", lv_count, 0);
        lv_code[15:8] = 8'd6; lv_arg[63:32] = 32'hB;
        tick();
        chk("lv_first_acc", lv_count, 1);
        tick();
        chk("lv_full", lv_count, 2);
        chk("lv_full_rdy", lv_ready, 0);
        lv_code[7:0] = 8'd3; lv_arg[31:0] = 32'h30;
        tick();
        lv_arg[31:0] = 32'h31;
        tick();
        chk("lv_same_code", lv_drops, 0);
        lv_code[7:0] = 8'd4; lv_arg[31:0] = 32'h40;
        tick();
        chk("lv_drops", lv_drops, 1);
        chk("lv_held", lv_count, 2);
        lv_out_ready = 1'b1;
        #1 chk("lv_rdy_indep", lv_ready, 0);
        tick();
        chk("lv_deq", lv_count, 1);
        chk("lv_rdy_after", lv_ready, 2'b01);
        chk("lv_head_ch", lv_out_channel, 1);
        chk("lv_head_code", lv_out_code, 6);
        chk("lv_head_arg", lv_out_arg, 32'hB);
        lv_out_ready = 1'b0;
        tick();
        chk("lv_refill", lv_count, 2);
        lv_out_ready = 1'b1;
        tick();
        chk("lv_ow_ch", lv_out_channel, 0);
        chk("lv_ow_code", lv_out_code, 4);
        chk("lv_ow_arg", lv_out_arg, 32'h40);
        chk("lv_drops_final", lv_drops, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
